// File: rtl/lsu_seq.sv
`default_nettype none
// ============================================================================
// Module   : lsu_seq
// Brief    : Sequential load/store unit; splits unaligned accesses into one or
//            two 8-byte memory beats and extends load results.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_seq #(
   parameter int N = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   input  logic           req_we,
   input  logic [N-1:0]   req_addr,
   input  logic [N-1:0]   req_wdata,
   input  logic [2:0]     memMask,
   input  logic           readOp,
   output logic           stall,
   output logic           done,
   output logic [N-1:0]   rdata,
   output logic           mem_req,
   output logic           mem_we,
   output logic [N-1:0]   mem_addr,
   output logic [N-1:0]   mem_wdata,
   output logic [7:0]     mem_wstrb,
   input  logic           mem_ready,
   input  logic [N-1:0]   mem_rdata,
   output logic [15:0]    split_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT1 = 2'd1,
      S_BEAT2 = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [N-1:0]     r_addr;
   logic [N-1:0]     r_wdata;
   logic [1:0]       r_size;
   logic             r_we;
   logic             r_sext;
   logic [N-1:0]     r_buf_lo;
   logic [N-1:0]     r_rdata;
   logic [15:0]      r_split_cnt;

   logic [1:0]       w_size;
   logic [2:0]       w_off;
   logic [3:0]       w_nbytes;
   logic [15:0]      w_strb16;
   logic [2*N-1:0]   w_wd128;
   logic             w_split;
   logic [N-1:0]     w_base;
   logic [N-1:0]     w_lo;
   logic [N-1:0]     w_raw;
   logic [N-1:0]     w_ext;

   // size code is log2 of the byte count
   always_comb begin
      w_size = 2'd0;
      if (memMask[2])      w_size = 2'd3;
      else if (memMask[1]) w_size = 2'd2;
      else if (memMask[0]) w_size = 2'd1;
   end

   assign w_off    = r_addr[2:0];
   assign w_nbytes = 4'd1 << r_size;
   assign w_strb16 = ((16'd1 << w_nbytes) - 16'd1) << w_off;
   assign w_wd128  = {{N{1'b0}}, r_wdata} << {w_off, 3'b000};
   assign w_split  = |w_strb16[15:8];
   assign w_base   = {r_addr[N-1:3], 3'b000};

   // The completing beat's data is used directly so rdata is ready in RESP.
   assign w_lo  = (r_state == S_BEAT1) ? mem_rdata : r_buf_lo;
   assign w_raw = N'({mem_rdata, w_lo} >> {w_off, 3'b000});

   always_comb begin
      w_ext = w_raw;
      case (r_size)
         2'd0:    w_ext = {{(N-8){r_sext & w_raw[7]}},   w_raw[7:0]};
         2'd1:    w_ext = {{(N-16){r_sext & w_raw[15]}}, w_raw[15:0]};
         2'd2:    w_ext = {{(N-32){r_sext & w_raw[31]}}, w_raw[31:0]};
         default: w_ext = w_raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_size      <= 2'd0;
         r_we        <= 1'b0;
         r_sext      <= 1'b0;
         r_buf_lo    <= '0;
         r_rdata     <= '0;
         r_split_cnt <= 16'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= w_size;
            r_we    <= req_we;
            r_sext  <= readOp;
         end
         if (r_state == S_BEAT1 && mem_ready) begin
            r_buf_lo <= mem_rdata;
            if (w_split && r_split_cnt != 16'hFFFF)
               r_split_cnt <= r_split_cnt + 16'd1;
         end
         if ((r_state == S_BEAT1 || r_state == S_BEAT2) && mem_ready && w_next == S_RESP)
            r_rdata <= r_we ? '0 : w_ext;
      end
   end

   always_comb begin
      w_next    = r_state;
      stall     = 1'b0;
      done      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = w_base;
      mem_wdata = '0;
      mem_wstrb = 8'h00;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_next = S_BEAT1;
               stall  = 1'b1;
            end
         end
         S_BEAT1: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_wstrb = w_strb16[7:0];
            mem_wdata = w_wd128[N-1:0];
            if (mem_ready) w_next = w_split ? S_BEAT2 : S_RESP;
         end
         S_BEAT2: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = w_base + N'(8);
            mem_wstrb = w_strb16[15:8];
            mem_wdata = w_wd128[2*N-1:N];
            if (mem_ready) w_next = S_RESP;
         end
         default: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
      endcase
      // Reset masks every outward request and handshake in the same cycle.
      if (reset) begin
         stall     = 1'b0;
         done      = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_wstrb = 8'h00;
      end
   end

   assign rdata     = r_rdata;
   assign split_cnt = r_split_cnt;

endmodule
`default_nettype wire

// File: doc/lsu_seq.md
LSU_SEQ -- requirements
Module: lsu_seq

Interface
REQ-001 Parameter: N, default 64, datapath and address width in bits; only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  the pipeline presents a load or store; held stable while stall=1.
REQ-005 req_we  input  1  1=store, 0=load.
REQ-006 req_addr  input  N  byte address, any alignment.
REQ-007 req_wdata  input  N  store data, right-justified.
REQ-008 memMask  input  3  access size, decoded with priority from bit 2: bit2=8B, else bit1=4B, else bit0=2B, else 1B.
REQ-009 readOp  input  1  load extension: 1=sign-extend, 0=zero-extend.
REQ-010 stall  output  1  holds the pipeline while the access is in progress.
REQ-011 done  output  1  one-cycle pulse marking completion; rdata is valid in the same cycle for loads.
REQ-012 rdata  output  N  extended load result.
REQ-013 mem_req, mem_we  output  1 each  memory beat request and beat write flag.
REQ-014 mem_addr  output  N  8-byte-aligned beat address; bits [2:0] are always 0.
REQ-015 mem_wdata  output  N; mem_wstrb  output  8  beat write data and byte strobes.
REQ-016 mem_ready  input  1; mem_rdata  input  N  beat acceptance and read data, both valid on the same cycle.
REQ-017 split_cnt  output  16  saturating count of accesses split into two beats.

Function
REQ-018 States: IDLE, BEAT1, BEAT2, RESP.
REQ-019 IDLE: when req_valid=1, latch addr, data, size, we and readOp, then go to BEAT1; later input changes are ignored until return to IDLE.
REQ-020 Strobes: strb16 = ((1<<size)-1) << addr[2:0], 16 bits wide; wd128 = {64'b0, wdata} << (8*addr[2:0]).
REQ-021 split = (strb16[15:8] != 0).
REQ-022 BEAT1 drives: mem_req=1, mem_addr=addr & ~7, mem_wstrb=strb16[7:0], mem_wdata=wd128[63:0], mem_we=we.
REQ-023 BEAT2 drives: mem_req=1, mem_addr=(addr & ~7)+8 modulo 2^64 (wrap from 0xFFFF_FFFF_FFFF_FFF8 to 0), mem_wstrb=strb16[15:8], mem_wdata=wd128[127:64].
REQ-024 Handshake: a beat completes on a cycle where mem_req=1 and mem_ready=1; mem_req and the beat outputs stay constant until completion; mem_req=0 in IDLE and RESP.
REQ-025 Load beat capture: BEAT1 captures mem_rdata into buf_lo; BEAT2 captures it into buf_hi.
REQ-026 Transitions: BEAT1 completing goes to BEAT2 if split, else to RESP. BEAT2 completing goes to RESP. RESP always goes to IDLE.
REQ-027 Load result: rdata = ({buf_hi, buf_lo} >> 8*addr[2:0])[63:0], truncated to size and extended per readOp. An 8B access is passed through unchanged.
REQ-028 rdata is registered, stable from RESP until the next load's RESP, and is 0 for stores.
REQ-029 done=1 only in RESP.
REQ-030 stall = (state==IDLE & req_valid) | state==BEAT1 | state==BEAT2; stall=0 in RESP so the pipeline advances exactly once.
REQ-031 Latency with mem_ready tied to 1: 2 cycles from acceptance to done for a non-split access, 3 for a split access.
REQ-032 split_cnt increments on each BEAT1->BEAT2 transition and saturates at 0xFFFF.
REQ-033 A single 8B access at offset 0 never splits; a 1B access never splits.
REQ-034 A req_valid asserted during RESP is not accepted until the following IDLE cycle.

Reset
REQ-035 When reset=1: state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, done=0, rdata=0, split_cnt=0, all latched fields cleared.
REQ-036 stall=0 during reset even if req_valid=1.
REQ-037 Reset during BEAT1 or BEAT2 abandons the access: no done pulse, and a beat already committed to memory is not undone.
REQ-038 Reset has priority over every handshake event in the same cycle.

Verification
REQ-039 Aligned store: addr=0x100, 8B, wdata=0x1122334455667788, ready=1 -> one beat at 0x100, wstrb=0xFF, done 2 cycles after acceptance, split_cnt=0.
REQ-040 Split load: addr=0x106, 4B, readOp=1, beat1 rdata=0xBBAA000000000000, beat2 rdata=0x00000000000080CC -> beats at 0x100 then 0x108, rdata=0xFFFFFFFF80CCBBAA, split_cnt=1.
REQ-041 Split store: addr=0x10F, 2B, wdata=0xABCD -> beat1 wstrb=0x80 with wdata[63:56]=0xCD; beat2 at 0x110, wstrb=0x01, wdata[7:0]=0xAB.
REQ-042 Backpressure: mem_ready held 0 for 5 cycles -> mem_addr, mem_wstrb, mem_wdata and mem_req stay constant, stall=1 throughout, done fires one cycle after ready.
REQ-043 Wrap and reset: 8B load at 0xFFFFFFFFFFFFFFFC -> beat2 mem_addr=0x0. A repeat of the access with reset asserted in BEAT2 -> next cycle IDLE, mem_req=0, done never pulses.
REQ-044 Zero-extend: 1B load at 0x7, readOp=0, rdata beat byte7=0x9C -> rdata=0x000000000000009C.
